// File: rtl/mc_control_if.sv
// Control bundle between mc_control and the RV32I multicycle datapath.
// The master side is the control unit. It takes the instruction fields and the ALU zero flag, and it drives the selects and strobes.
interface mc_control_if #(
  parameter int ALU_W = 4
);
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             funct7b5;
  logic             zero;
  logic             pc_write;
  logic             adr_src;
  logic             mem_write;
  logic             ir_write;
  logic             reg_write;
  logic [1:0]       result_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       imm_src;
  logic [ALU_W-1:0] alu_ctrl;
  logic             instr_done;
  logic             illegal;

  modport master (
    input  op, funct3, funct7b5, zero,
    output pc_write, adr_src, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_ctrl,
           instr_done, illegal
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  pc_write, adr_src, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_ctrl,
           instr_done, illegal
  );
endinterface

// File: rtl/mc_control.sv
// Moore control FSM for the RV32I multicycle core: fetch/decode/execute/memory/writeback.
// Optional macro MC_CONTROL_BNE_EN accepts bne (funct3=001) into the branch state.
module mc_control #(
  parameter int ALU_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  mc_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_ILLEGAL
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(0);
  localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(1);
  localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(2);
  localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(3);

  state_e           state_q, state_d;
  logic             f3Legal, rLegal, branchLegal, branchTaken;
  logic [ALU_W-1:0] aluDecoded;
  logic             pcWrite, adrSrc, memWrite, irWrite, regWrite;
  logic [1:0]       resultSrc, aluSrcA, aluSrcB, immSrc;
  logic [ALU_W-1:0] aluCtrl;
  logic             instrDone, illegalState;

  // Only add/sub, or and and exist; funct7b5 picks sub only on R-type with funct3=000.
  assign f3Legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b110) || (bus.funct3 == 3'b111);
  assign rLegal  = f3Legal && !(bus.funct7b5 && (bus.funct3 != 3'b000));

`ifdef MC_CONTROL_BNE_EN
  assign branchLegal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001);
  assign branchTaken = bus.zero ^ bus.funct3[0];
`else
  assign branchLegal = (bus.funct3 == 3'b000);
  assign branchTaken = bus.zero;
`endif

  always_comb begin
    aluDecoded = ALU_ADD;
    case (bus.funct3)
      3'b000:  aluDecoded = (bus.op[5] && bus.funct7b5) ? ALU_SUB : ALU_ADD;
      3'b110:  aluDecoded = ALU_OR;
      3'b111:  aluDecoded = ALU_AND;
      default: aluDecoded = ALU_ADD;
    endcase
  end

  always_comb begin
    immSrc = 2'b00;
    case (bus.op)
      OP_STORE:  immSrc = 2'b01;
      OP_BRANCH: immSrc = 2'b10;
      OP_JAL:    immSrc = 2'b11;
      default:   immSrc = 2'b00;
    endcase
  end

  // An undefined state encoding falls back to FETCH, so the FSM cannot lock up.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = rLegal ? S_EXECR : S_ILLEGAL;
          OP_ITYPE:          state_d = f3Legal ? S_EXECI : S_ILLEGAL;
          OP_BRANCH:         state_d = branchLegal ? S_BEQ : S_ILLEGAL;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    pcWrite      = 1'b0;
    adrSrc       = 1'b0;
    memWrite     = 1'b0;
    irWrite      = 1'b0;
    regWrite     = 1'b0;
    resultSrc    = 2'b00;
    aluSrcA      = 2'b00;
    aluSrcB      = 2'b00;
    aluCtrl      = ALU_ADD;
    instrDone    = 1'b0;
    illegalState = 1'b0;
    case (state_q)
      S_FETCH: begin
        irWrite   = 1'b1;
        aluSrcB   = 2'b10;
        resultSrc = 2'b10;
        pcWrite   = 1'b1;
      end
      S_DECODE: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
      end
      S_MEMADR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
      end
      S_MEMREAD: adrSrc = 1'b1;
      S_MEMWB: begin
        resultSrc = 2'b01;
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      S_MEMWRITE: begin
        adrSrc    = 1'b1;
        memWrite  = 1'b1;
        instrDone = 1'b1;
      end
      S_EXECR: begin
        aluSrcA = 2'b10;
        aluCtrl = aluDecoded;
      end
      S_EXECI: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        aluCtrl = aluDecoded;
      end
      S_ALUWB: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      S_BEQ: begin
        aluSrcA   = 2'b10;
        aluCtrl   = ALU_SUB;
        pcWrite   = branchTaken;
        instrDone = 1'b1;
      end
      S_JAL: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b10;
        pcWrite = 1'b1;
      end
      S_ILLEGAL: illegalState = 1'b1;
      default: ;
    endcase
  end

  // Strobes are forced low while reset is asserted, even though the state already reads FETCH.
  assign bus.pc_write   = pcWrite & rst_n;
  assign bus.ir_write   = irWrite & rst_n;
  assign bus.reg_write  = regWrite & rst_n;
  assign bus.mem_write  = memWrite & rst_n;
  assign bus.instr_done = instrDone & rst_n;
  assign bus.illegal    = illegalState & rst_n;
  assign bus.adr_src    = adrSrc;
  assign bus.result_src = resultSrc;
  assign bus.alu_src_a  = aluSrcA;
  assign bus.alu_src_b  = aluSrcB;
  assign bus.imm_src    = immSrc;
  assign bus.alu_ctrl   = aluCtrl;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: the driver queues hand-computed per-cycle output vectors, and the monitor compares them.
// Expectations for bne follow MC_CONTROL_BNE_EN.
module tb_mc_control;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [3:0] alu_ctrl;
    logic       instr_done;
    logic       illegal;
  } outv_t;

  typedef struct {
    outv_t v;
    string name;
  } sbItem_t;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JL   = 7'b1101111;
  localparam logic [6:0] BAD  = 7'b0000000;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  sbItem_t sbq[$];
  event pushEv;

  mc_control_if #(.ALU_W(4)) bus();

  mc_control #(.ALU_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written per-state output vectors; the argument order matches the outv_t fields.
  function automatic outv_t mk(input logic pcw, input logic adr, input logic mw, input logic irw,
                               input logic rw, input logic [1:0] rs, input logic [1:0] sa,
                               input logic [1:0] sb, input logic [1:0] imm, input logic [3:0] alu,
                               input logic done, input logic ill);
    outv_t r;
    r = '{pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, done, ill};
    return r;
  endfunction

  function automatic outv_t sReset(input logic [1:0] imm);
    return mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm, 4'd0, 0, 0);
  endfunction
  function automatic outv_t sFetch(input logic [1:0] imm);
    return mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm, 4'd0, 0, 0);
  endfunction
  function automatic outv_t sDecode(input logic [1:0] imm);
    return mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 4'd0, 0, 0);
  endfunction
  function automatic outv_t sMemAdr(input logic [1:0] imm);
    return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 4'd0, 0, 0);
  endfunction
  function automatic outv_t sMemRead();
    return mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0, 0, 0);
  endfunction
  function automatic outv_t sMemWb();
    return mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 4'd0, 1, 0);
  endfunction
  function automatic outv_t sMemWrite();
    return mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 4'd0, 1, 0);
  endfunction
  function automatic outv_t sExec(input logic [1:0] sb, input logic [3:0] alu);
    return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, sb, 2'b00, alu, 0, 0);
  endfunction
  function automatic outv_t sAluWb(input logic [1:0] imm);
    return mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 4'd0, 1, 0);
  endfunction
  function automatic outv_t sBranch(input logic pcw);
    return mk(pcw, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 4'd1, 1, 0);
  endfunction
  function automatic outv_t sJal();
    return mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 4'd0, 0, 0);
  endfunction
  function automatic outv_t sIllegal(input logic [1:0] imm);
    return mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 4'd0, 0, 1);
  endfunction

  task automatic pushExp(input outv_t e, input string nm);
    sbItem_t it;
    it.v    = e;
    it.name = nm;
    sbq.push_back(it);
    -> pushEv;
  endtask

  task automatic applyStimulus(input logic rstn, input logic [6:0] o, input logic [2:0] f3,
                               input logic f7, input logic z, input outv_t e, input string nm);
    @(posedge clk);
    #1;
    rst_n        = rstn;
    bus.op       = o;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
    bus.zero     = z;
    pushExp(e, nm);
  endtask

  task automatic checkOutput(input sbItem_t it);
    outv_t act;
    act = '{bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.reg_write,
            bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.imm_src, bus.alu_ctrl,
            bus.instr_done, bus.illegal};
    checks++;
    if (act !== it.v) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b (t=%0t)", it.name, act, it.v, $time);
    end
  endtask

  initial begin
    forever begin
      @(pushEv);
      #2;
      while (sbq.size() > 0) checkOutput(sbq.pop_front());
    end
  end

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.op       = LW;
    bus.funct3   = 3'b010;
    bus.funct7b5 = 1'b0;
    bus.zero     = 1'b0;

    applyStimulus(0, LW, 3'b010, 0, 0, sReset(2'b00), "reset_state");
    applyStimulus(1, LW, 3'b010, 0, 0, sFetch(2'b00), "lw_fetch");
    applyStimulus(1, LW, 3'b010, 0, 0, sDecode(2'b00), "lw_decode");
    applyStimulus(1, LW, 3'b010, 0, 0, sMemAdr(2'b00), "lw_memadr");
    applyStimulus(1, LW, 3'b010, 0, 0, sMemRead(), "lw_memread");
    applyStimulus(1, LW, 3'b010, 0, 0, sMemWb(), "lw_memwb");

    applyStimulus(1, SW, 3'b010, 0, 0, sFetch(2'b01), "sw_fetch");
    applyStimulus(1, SW, 3'b010, 0, 0, sDecode(2'b01), "sw_decode");
    applyStimulus(1, SW, 3'b010, 0, 0, sMemAdr(2'b01), "sw_memadr");
    applyStimulus(1, SW, 3'b010, 0, 0, sMemWrite(), "sw_memwrite");

    applyStimulus(1, RT, 3'b000, 1, 0, sFetch(2'b00), "sub_fetch");
    applyStimulus(1, RT, 3'b000, 1, 0, sDecode(2'b00), "sub_decode");
    applyStimulus(1, RT, 3'b000, 1, 0, sExec(2'b00, 4'd1), "sub_execr");
    applyStimulus(1, RT, 3'b000, 1, 0, sAluWb(2'b00), "sub_aluwb");

    applyStimulus(1, IT, 3'b000, 1, 0, sFetch(2'b00), "addi_fetch");
    applyStimulus(1, IT, 3'b000, 1, 0, sDecode(2'b00), "addi_decode");
    applyStimulus(1, IT, 3'b000, 1, 0, sExec(2'b01, 4'd0), "addi_execi");
    applyStimulus(1, IT, 3'b000, 1, 0, sAluWb(2'b00), "addi_aluwb");

    applyStimulus(1, IT, 3'b110, 0, 0, sFetch(2'b00), "ori_fetch");
    applyStimulus(1, IT, 3'b110, 0, 0, sDecode(2'b00), "ori_decode");
    applyStimulus(1, IT, 3'b110, 0, 0, sExec(2'b01, 4'd3), "ori_execi");
    applyStimulus(1, IT, 3'b110, 0, 0, sAluWb(2'b00), "ori_aluwb");

    applyStimulus(1, RT, 3'b111, 0, 0, sFetch(2'b00), "and_fetch");
    applyStimulus(1, RT, 3'b111, 0, 0, sDecode(2'b00), "and_decode");
    applyStimulus(1, RT, 3'b111, 0, 0, sExec(2'b00, 4'd2), "and_execr");
    applyStimulus(1, RT, 3'b111, 0, 0, sAluWb(2'b00), "and_aluwb");

    applyStimulus(1, BR, 3'b000, 0, 1, sFetch(2'b10), "beqT_fetch");
    applyStimulus(1, BR, 3'b000, 0, 1, sDecode(2'b10), "beqT_decode");
    applyStimulus(1, BR, 3'b000, 0, 1, sBranch(1'b1), "beqT_branch");
    applyStimulus(1, BR, 3'b000, 0, 0, sFetch(2'b10), "beqN_fetch");
    applyStimulus(1, BR, 3'b000, 0, 0, sDecode(2'b10), "beqN_decode");
    applyStimulus(1, BR, 3'b000, 0, 0, sBranch(1'b0), "beqN_branch");

    applyStimulus(1, JL, 3'b000, 0, 0, sFetch(2'b11), "jal_fetch");
    applyStimulus(1, JL, 3'b000, 0, 0, sDecode(2'b11), "jal_decode");
    applyStimulus(1, JL, 3'b000, 0, 0, sJal(), "jal_jal");
    applyStimulus(1, JL, 3'b000, 0, 0, sAluWb(2'b11), "jal_aluwb");

    // A second lw is interrupted by reset in the middle of its MEMWB cycle.
    applyStimulus(1, LW, 3'b010, 0, 0, sFetch(2'b00), "lw2_fetch");
    applyStimulus(1, LW, 3'b010, 0, 0, sDecode(2'b00), "lw2_decode");
    applyStimulus(1, LW, 3'b010, 0, 0, sMemAdr(2'b00), "lw2_memadr");
    applyStimulus(1, LW, 3'b010, 0, 0, sMemRead(), "lw2_memread");
    applyStimulus(1, LW, 3'b010, 0, 0, sMemWb(), "lw2_memwb");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    pushExp(sReset(2'b00), "reset_mid_memwb");
    applyStimulus(1, RT, 3'b110, 1, 0, sFetch(2'b00), "release_fetch");
    applyStimulus(1, RT, 3'b110, 1, 0, sDecode(2'b00), "badR_decode");
    applyStimulus(1, RT, 3'b110, 1, 0, sIllegal(2'b00), "badR_illegal");

    applyStimulus(0, BAD, 3'b000, 0, 0, sReset(2'b00), "reset_from_illegal");
    applyStimulus(1, BAD, 3'b000, 0, 0, sFetch(2'b00), "bad_fetch");
    applyStimulus(1, BAD, 3'b000, 0, 0, sDecode(2'b00), "bad_decode");
    for (int i = 0; i < 11; i++)
      applyStimulus(1, BAD, 3'b000, 0, i[0], sIllegal(2'b00), "bad_illegal_hold");

    applyStimulus(0, BR, 3'b001, 0, 0, sReset(2'b10), "reset_before_bne");
    applyStimulus(1, BR, 3'b001, 0, 0, sFetch(2'b10), "bne_fetch");
    applyStimulus(1, BR, 3'b001, 0, 0, sDecode(2'b10), "bne_decode");
`ifdef MC_CONTROL_BNE_EN
    applyStimulus(1, BR, 3'b001, 0, 0, sBranch(1'b1), "bne_taken");
    applyStimulus(1, BR, 3'b001, 0, 1, sFetch(2'b10), "bne2_fetch");
    applyStimulus(1, BR, 3'b001, 0, 1, sDecode(2'b10), "bne2_decode");
    applyStimulus(1, BR, 3'b001, 0, 1, sBranch(1'b0), "bne_not_taken");
    applyStimulus(1, IT, 3'b000, 0, 0, sFetch(2'b00), "post_bne_fetch");
`else
    applyStimulus(1, BR, 3'b001, 0, 0, sIllegal(2'b10), "bne_illegal");
    applyStimulus(1, BR, 3'b001, 0, 0, sIllegal(2'b10), "bne_illegal_hold");
`endif

    @(posedge clk);
    #5;
    if (sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
